// File: rtl/keypad_scan_input.sv
// rtl/keypad_scan_input.sv - 4x4 hex keypad scanner with debounce and nibble shift-in word
module keypad_scan_input #(
  parameter int SCAN_DIV       = 150000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_col,
  output logic [3:0]  key_row,
  input  logic        clear,
  output logic [31:0] data,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  logic [3:0]    col_meta, col_sync;
  logic [DW-1:0] div;
  logic [1:0]    row;
  logic          tick, scan_end;
  logic          hit_seen;
  logic [3:0]    hit_code;
  logic          row_hit;
  logic [1:0]    col_idx;
  logic          pressed;
  logic [3:0]    code;
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    cand, cand_next;
  logic          accept;

  assign tick     = (div == DW'(SCAN_DIV - 1));
  assign scan_end = tick && (row == 2'd3);
  assign key_row  = ~(4'b0001 << row);

  always_comb begin
    row_hit = (col_sync != 4'hF);
    if (!col_sync[0])      col_idx = 2'd0;
    else if (!col_sync[1]) col_idx = 2'd1;
    else if (!col_sync[2]) col_idx = 2'd2;
    else                   col_idx = 2'd3;
    // An earlier row in this scan outranks the row being sampled now.
    pressed = hit_seen || row_hit;
    code    = hit_seen ? hit_code : {row, col_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
      div      <= '0;
      row      <= 2'd0;
      hit_seen <= 1'b0;
      hit_code <= 4'h0;
    end else begin
      col_meta <= key_col;
      col_sync <= col_meta;
      if (tick) begin
        div <= '0;
        row <= row + 2'd1;
        if (scan_end) begin
          hit_seen <= 1'b0;
        end else if (row_hit && !hit_seen) begin
          hit_seen <= 1'b1;
          hit_code <= {row, col_idx};
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    accept     = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (pressed) begin
            cand_next = code;
            if (DEBOUNCE_SCANS == 1) begin
              accept     = 1'b1;
              state_next = HELD;
              cnt_next   = '0;
            end else begin
              state_next = PRESS_CHK;
              cnt_next   = CW'(1);
            end
          end
        end
        PRESS_CHK: begin
          if (pressed && code == cand) begin
            cnt_next = cnt + 1'b1;
            if (cnt_next == CW'(DEBOUNCE_SCANS)) begin
              accept     = 1'b1;
              state_next = HELD;
              cnt_next   = '0;
            end
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        HELD: begin
          if (!pressed) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              state_next = RELEASE_CHK;
              cnt_next   = CW'(1);
            end
          end
        end
        RELEASE_CHK: begin
          if (!pressed) begin
            cnt_next = cnt + 1'b1;
            if (cnt_next == CW'(DEBOUNCE_SCANS)) begin
              state_next = IDLE;
              cnt_next   = '0;
            end
          end else begin
            state_next = HELD;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'h0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      data      <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cand      <= cand_next;
      key_valid <= accept;
      if (accept) key_code <= cand_next;
      // Clear wins over a same-cycle accept for the word, not for the strobe.
      if (clear)       data <= '0;
      else if (accept) data <= {data[27:0], cand_next};
    end
  end

endmodule

// File: tb/tb_keypad_scan_input.sv
// tb/tb_keypad_scan_input.sv - directed self-checking bench for keypad_scan_input
module tb_keypad_scan_input;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic        clear;
  logic [31:0] data;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [15:0] keys;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  int p0;
  int press_cyc;
  logic [3:0] exp_rows [4];

  keypad_scan_input #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .clear(clear), .data(data), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a closed key shorts its column to the driven row.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && keys[r*4+c]) key_col[c] = 1'b0;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (key_valid === 1'b1) begin
      pulses    = pulses + 1;
      pulse_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic scans(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic press_release(input int k, input int hold, input int rel);
    keys = '0;
    keys[k] = 1'b1;
    scans(hold);
    keys = '0;
    scans(rel);
  endtask

  task automatic wait_row(input logic [3:0] want);
    int n;
    n = 0;
    while (key_row !== want && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_row", 32'(n < 64), 32'd1);
  endtask

  initial begin
    exp_rows[0] = 4'b1110;
    exp_rows[1] = 4'b1101;
    exp_rows[2] = 4'b1011;
    exp_rows[3] = 4'b0111;
    rst = 1'b1;
    clear = 1'b0;
    keys = '0;
    repeat (2) @(negedge clk);
    check_val("rst_key_row", 32'(key_row), 32'(4'b1110));
    check_val("rst_data", data, 32'h0);
    check_val("rst_key_valid", 32'(key_valid), 32'd0);
    check_val("rst_key_code", 32'(key_code), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      check_val("row_cycle", 32'(key_row), 32'(exp_rows[i]));
      repeat (4) @(negedge clk);
    end

    p0 = pulses;
    keys[6] = 1'b1;
    press_cyc = cyc;
    scans(10);
    check_val("single_pulses", 32'(pulses - p0), 32'd1);
    check_val("single_code", 32'(key_code), 32'h6);
    check_val("single_data", data, 32'h00000006);
    check_val("single_latency_ok", 32'((pulse_cyc - press_cyc) <= 51), 32'd1);
    keys = '0;
    scans(4);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_val("clear_data", data, 32'h0);
    p0 = pulses;
    for (int d = 1; d <= 9; d++) press_release(d, 4, 4);
    check_val("digits_pulses", 32'(pulses - p0), 32'd9);
    check_val("digits_data", data, 32'h23456789);
    check_val("digits_code", 32'(key_code), 32'h9);

    p0 = pulses;
    press_release(10, 1, 4);
    check_val("bounce_short", 32'(pulses - p0), 32'd0);
    keys = '0; keys[10] = 1'b1; scans(4);
    keys = '0; scans(1);
    keys[10] = 1'b1; scans(3);
    keys = '0; scans(4);
    check_val("bounce_regrab_pulses", 32'(pulses - p0), 32'd1);
    check_val("bounce_code", 32'(key_code), 32'hA);
    check_val("bounce_data", data, 32'h3456789A);

    p0 = pulses;
    keys = '0; keys[5] = 1'b1; keys[10] = 1'b1;
    scans(4);
    keys = '0;
    scans(4);
    check_val("prio_pulses", 32'(pulses - p0), 32'd1);
    check_val("prio_code", 32'(key_code), 32'h5);
    check_val("prio_data", data, 32'h456789A5);

    p0 = pulses;
    wait_row(4'b0111);
    wait_row(4'b1110);
    keys[3] = 1'b1;
    repeat (31) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_val("clracc_valid", 32'(key_valid), 32'd1);
    check_val("clracc_code", 32'(key_code), 32'h3);
    check_val("clracc_data", data, 32'h0);
    keys = '0;
    scans(4);
    check_val("clracc_pulses", 32'(pulses - p0), 32'd1);

    wait_row(4'b0111);
    wait_row(4'b1110);
    keys[7] = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    repeat (31) @(negedge clk);
    check_val("rst_mid_nopulse", 32'(pulses - p0), 32'd0);
    check_val("rst_mid_data0", data, 32'h0);
    repeat (2) @(negedge clk);
    check_val("rst_mid_pulse", 32'(pulses - p0), 32'd1);
    check_val("rst_mid_code", 32'(key_code), 32'h7);
    check_val("rst_mid_data", data, 32'h00000007);
    keys = '0;
    scans(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
